// File: rtl/io_pkg.sv
// Shared encodings for the decompressor lane scheduler: FSM states and lane indices.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECOMP = 2'b01,
    DONE   = 2'b10,
    CALC   = 2'b11
  } state_t;

  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_U    = 2;
  localparam int LANE_CTRL = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first eligible lane found by
// searching upward from rr_ptr, wrapping around the lane count.
module rr_arbiter #(
  parameter int N_LANES = 4,
  parameter int PW      = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic [N_LANES-1:0] eligible,
  input  logic [PW-1:0]      rr_ptr,
  output logic [N_LANES-1:0] pick
);

  int   idx;
  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_LANES; k++) begin
      idx = (int'(rr_ptr) + k) % N_LANES;
      if (!found && eligible[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decomp_scheduler.sv
// Sequencer and bus arbiter for the four decompressor lanes sharing the IO word
// bus: launches a round on irq, grants one lane at a time, tracks end-of-object.
module decomp_scheduler
  import io_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int U_OBJS  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               irq,
  input  logic               process,
  input  logic [N_LANES-1:0] req,
  input  logic [N_LANES-1:0] eob,
  input  logic               word_valid,
  input  logic               ready,
  output logic [N_LANES-1:0] start,
  output logic [N_LANES-1:0] grant,
  output logic               next,
  output logic               all_done,
  output logic               busy,
  output logic               err_early_calc
);

  localparam int                 PW       = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [3:0]         U_TARGET = 4'(U_OBJS);
  localparam logic [N_LANES-1:0] U_BIT    = N_LANES'(1) << LANE_U;

  state_t             state, state_next;
  logic [N_LANES-1:0] finish, eligible, pick, eob_xfer, finish_set;
  logic [PW-1:0]      rr_ptr, gnt_idx, ptr_after;
  logic [3:0]         u_cnt, u_cnt_inc;
  logic               xfer, u_eob;

  rr_arbiter #(.N_LANES(N_LANES), .PW(PW)) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .pick     (pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (irq && !process) state_next = DECOMP;
      DECOMP:  if (&finish)         state_next = DONE;
      DONE:    if (irq && process)  state_next = CALC;
      CALC:    if (ready)           state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // A word moves only when the current grant holder sees word_valid; the U lane
  // counts objects and saturates at its target instead of finishing on first eob.
  always_comb begin
    eligible   = req & ~finish;
    xfer       = (state == DECOMP) && (|grant) && word_valid;
    eob_xfer   = xfer ? (grant & eob) : '0;
    u_eob      = eob_xfer[LANE_U];
    u_cnt_inc  = (u_cnt == U_TARGET) ? u_cnt : u_cnt + 4'd1;
    finish_set = eob_xfer & ~U_BIT;
    if (u_eob && (u_cnt_inc == U_TARGET)) finish_set = finish_set | U_BIT;
    gnt_idx = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (grant[i]) gnt_idx = PW'(i);
    end
    ptr_after = (gnt_idx == PW'(N_LANES - 1)) ? '0 : gnt_idx + PW'(1);
  end

  assign all_done = (state == DONE) || (state == CALC);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start          <= '0;
      grant          <= '0;
      next           <= 1'b0;
      finish         <= '0;
      u_cnt          <= '0;
      rr_ptr         <= '0;
      err_early_calc <= 1'b0;
    end else begin
      start <= '0;
      next  <= 1'b0;
      if (state == IDLE && state_next == DECOMP) begin
        start  <= '1;
        finish <= '0;
        u_cnt  <= '0;
      end
      if (state == DECOMP && irq && process) err_early_calc <= 1'b1;
      // Every completed transfer drops the grant for one cycle before re-arbitration.
      if (state != DECOMP || state_next != DECOMP) begin
        grant <= '0;
      end else if (grant == '0) begin
        grant <= pick;
      end else if (word_valid) begin
        grant  <= '0;
        rr_ptr <= ptr_after;
      end else if ((grant & req) == '0) begin
        grant <= '0;
      end
      if (|eob_xfer) finish <= finish | finish_set;
      if (u_eob) begin
        u_cnt <= u_cnt_inc;
        next  <= 1'b1;
      end
    end
  end

endmodule
